// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-register stall vector, one-cycle flush with PC
// redirect, MEM-stall watchdog. Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(STALL_TIMEOUT);

  state_t      state_r;
  logic [31:0] epc_r;
  logic [31:0] redirect_pc_r;
  logic        flush_r;
  logic        redirect_valid_r;
  logic        timeout_r;
  logic [15:0] wd_r;
  logic [15:0] wd_next_s;
  logic [4:0]  stall_s;

  // Stall vector: everything upstream of the deepest requesting stage holds; WB never stalls
  always_comb begin
    stall_s = 5'b00000;
    if (!rst) begin
      stall_s = 5'b00000;
    end else if (state_r == FLUSH) begin
      stall_s = 5'b00000;
    end else if (stall_req_mem) begin
      stall_s = 5'b01111;
    end else if (stall_req_ex) begin
      stall_s = 5'b00111;
    end else if (stall_req_id) begin
      stall_s = 5'b00011;
    end else if (stall_req_if) begin
      stall_s = 5'b00001;
    end else begin
      stall_s = 5'b00000;
    end
  end

  // Watchdog next value: counts consecutive MEM stalls, saturating at the threshold
  always_comb begin
    wd_next_s = 16'd0;
    if ((state_r == FLUSH) || !stall_req_mem) begin
      wd_next_s = 16'd0;
    end else if (wd_r == TIMEOUT_C) begin
      wd_next_s = wd_r;
    end else begin
      wd_next_s = wd_r + 16'd1;
    end
  end

  // Watchdog counter and single-shot timeout pulse on the cycle the count hits the threshold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_r      <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      wd_r      <= wd_next_s;
      timeout_r <= (wd_next_s == TIMEOUT_C) && (wd_r != TIMEOUT_C);
    end
  end

  // Exception FSM; first accepted exception wins, later requests are dropped until IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      epc_r            <= 32'd0;
      redirect_pc_r    <= 32'd0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          flush_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
          if (exc_req) begin
            epc_r <= exc_pc;
            if (stall_req_mem) begin
              state_r <= EXC_WAIT;
            end else begin
              state_r          <= FLUSH;
              flush_r          <= 1'b1;
              redirect_valid_r <= 1'b1;
              redirect_pc_r    <= exc_pc;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXC_WAIT: begin
          if (!stall_req_mem) begin
            state_r          <= FLUSH;
            flush_r          <= 1'b1;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= epc_r;
          end else begin
            state_r          <= EXC_WAIT;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
          end
        end
        FLUSH: begin
          state_r          <= IDLE;
          flush_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
        end
        default: begin
          state_r          <= IDLE;
          flush_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Free-running perf counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (stall_s[0]) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (state_r == FLUSH) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flush_count  = perf_flush_r;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

  assign stall          = stall_s;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign timeout        = timeout_r;

endmodule
